// File: rtl/mmu_ldst_sequencer_pkg.sv
// rtl/mmu_ldst_sequencer_pkg.sv - shared state encoding, width defaults and decoder write codes
package mmu_ldst_sequencer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 4;
  localparam int DEF_MEM_AW = 4;

  // Write codes shared with the upstream decoder; 2'b11 marks an operation with neither flag set.
  localparam logic [1:0] WR_STORE   = 2'b00;
  localparam logic [1:0] WR_LOAD    = 2'b01;
  localparam logic [1:0] WR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WB   = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Load wins when both flags are set.
  function automatic logic [1:0] op_code(input logic ld, input logic st);
    if (ld) begin
      return WR_LOAD;
    end else if (st) begin
      return WR_STORE;
    end else begin
      return WR_INVALID;
    end
  endfunction

endpackage

// File: rtl/mmu_ldst_sequencer_if.sv
// rtl/mmu_ldst_sequencer_if.sv - decoder, memory and register-file signals of the load/store sequencer
interface mmu_ldst_sequencer_if
  import mmu_ldst_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MEM_AW = DEF_MEM_AW
) ();

  logic              dec_valid;
  logic              dec_ready;
  logic              dec_st;
  logic              dec_ld;
  logic [REG_AW-1:0] dec_reg_addr;
  logic [MEM_AW-1:0] dec_mem_addr;

  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic              done;
  logic              err;

  modport master (
    input  dec_valid, dec_st, dec_ld, dec_reg_addr, dec_mem_addr,
    input  mem_ack, mem_rdata, rf_rdata,
    output dec_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output rf_raddr, rf_we, rf_waddr, rf_wdata, done, err
  );

  modport slave (
    output dec_valid, dec_st, dec_ld, dec_reg_addr, dec_mem_addr,
    output mem_ack, mem_rdata, rf_rdata,
    input  dec_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_raddr, rf_we, rf_waddr, rf_wdata, done, err
  );

endinterface

// File: rtl/mmu_ldst_sequencer.sv
// rtl/mmu_ldst_sequencer.sv - load/store sequencer after the MMU decoder; MMU_TIMEOUT_EN adds a REQ abort timer
module mmu_ldst_sequencer
  import mmu_ldst_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MEM_AW = DEF_MEM_AW
`ifdef MMU_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  mmu_ldst_sequencer_if.master bus
);

  state_e            state_q, state_d;
  logic              st_q, st_d;
  logic              ld_q, ld_d;
  logic [REG_AW-1:0] reg_q, reg_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic accept;
  logic timeout;

  assign accept = (state_q == IDLE) && bus.dec_valid;

`ifdef MMU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Wait counter: zero outside REQ, counts REQ cycles that saw no ack.
  always_comb begin
    cnt_d = '0;
    if ((state_q == REQ) && !bus.mem_ack) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Abort in the REQ cycle that would be the TIMEOUT_CYC-th without ack; an ack in that cycle wins.
  assign timeout = (state_q == REQ) && !bus.mem_ack && (cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: invalid ops skip memory, loads take a writeback cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_code(bus.dec_ld, bus.dec_st) == WR_INVALID) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d = ld_q ? WB : DONE;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation fields are captured on acceptance; load data is captured on the acking REQ cycle.
  always_comb begin
    st_d   = st_q;
    ld_d   = ld_q;
    reg_d  = reg_q;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      st_d   = bus.dec_st;
      ld_d   = bus.dec_ld;
      reg_d  = bus.dec_reg_addr;
      addr_d = bus.dec_mem_addr;
    end
    if ((state_q == REQ) && bus.mem_ack && ld_q) begin
      data_d = bus.mem_rdata;
    end
  end

  // Latched operation fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= 1'b0;
      ld_q   <= 1'b0;
      reg_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      ld_q   <= ld_d;
      reg_q  <= reg_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Outputs decoded from the current state; request fields come from latched values so they hold until ack.
  always_comb begin
    bus.dec_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rf_raddr  = reg_q;
    bus.rf_we     = 1'b0;
    bus.rf_waddr  = '0;
    bus.rf_wdata  = '0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    case (state_q)
      IDLE: bus.dec_ready = 1'b1;
      REQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = st_q && !ld_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = bus.rf_rdata;
      end
      WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = reg_q;
        bus.rf_wdata = data_q;
      end
      DONE:    bus.done = 1'b1;
      ERR:     bus.err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmu_ldst_sequencer.sv
// tb/tb_mmu_ldst_sequencer.sv - scoreboard bench for mmu_ldst_sequencer
module tb_mmu_ldst_sequencer;

  localparam int DW = 32;
  localparam int RA = 4;
  localparam int MA = 4;

  typedef struct {
    bit             ld;
    bit             st;
    bit             tmo;
    logic [RA-1:0]  r;
    logic [MA-1:0]  a;
  } stim_t;

  // kind: 0 store, 1 load, 2 invalid
  typedef struct {
    int             kind;
    bit             tmo;
    logic [RA-1:0]  r;
    logic [MA-1:0]  a;
    logic [DW-1:0]  d;
    int             t;
  } op_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mmu_ldst_sequencer_if #(.DATA_W(DW), .REG_AW(RA), .MEM_AW(MA)) bus ();

  mmu_ldst_sequencer #(
    .DATA_W(DW), .REG_AW(RA), .MEM_AW(MA)
`ifdef MMU_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] rf_m  [16];
  logic [DW-1:0] mem_m [16];

  assign bus.rf_rdata = rf_m[bus.rf_raddr];

  stim_t stim_q[$];
  op_t   sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int req_cyc = 0;
  int req_len_last = 0;
  int req_total = 0;
  int ack_delay = 0;
  int n_done = 0;
  int n_errp = 0;
  int n_rfwe = 0;
  int done_lat_last = 0;
  bit prev_rfwe = 1'b0;
  int base_done, base_err, base_rfwe, base_req;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at each falling edge: check outputs, answer memory, drive decoder.
  task automatic monitor();
    op_t   op;
    stim_t s;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    if (bus.mem_req) begin
      req_cyc++;
      req_total++;
      chk("req_has_op", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        op = sb_q[0];
        chk("req_not_invalid", op.kind != 2, 1);
        chk("req_we", bus.mem_we, op.kind == 0);
        chk("req_addr", bus.mem_addr, op.a);
        if (op.kind == 0) chk("req_wdata", bus.mem_wdata, op.d);
        if (req_cyc == ack_delay + 1) begin
          bus.mem_ack = 1'b1;
          if (op.kind == 1) bus.mem_rdata = mem_m[op.a];
          else mem_m[bus.mem_addr] = bus.mem_wdata;
        end
      end
    end else begin
      if (req_cyc > 0) req_len_last = req_cyc;
      req_cyc = 0;
    end
    if (bus.rf_we) begin
      n_rfwe++;
      chk("wb_has_op", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        op = sb_q[0];
        chk("wb_is_load", op.kind, 1);
        chk("wb_addr", bus.rf_waddr, op.r);
        chk("wb_data", bus.rf_wdata, op.d);
        rf_m[bus.rf_waddr] = bus.rf_wdata;
      end
    end
    if (bus.done) begin
      n_done++;
      chk("done_has_op", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        op = sb_q.pop_front();
        chk("done_kind_ok", (op.kind != 2) && !op.tmo, 1);
        if (op.kind == 1) chk("done_after_wb", prev_rfwe, 1);
        done_lat_last = cyc - op.t;
      end
    end
    if (bus.err) begin
      n_errp++;
      chk("err_has_op", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        op = sb_q.pop_front();
        chk("err_kind_ok", (op.kind == 2) || op.tmo, 1);
      end
    end
    prev_rfwe = bus.rf_we;
    if (stim_q.size() > 0) begin
      s = stim_q[0];
      bus.dec_valid    = 1'b1;
      bus.dec_ld       = s.ld;
      bus.dec_st       = s.st;
      bus.dec_reg_addr = s.r;
      bus.dec_mem_addr = s.a;
      if (bus.dec_ready) begin
        op.kind = s.ld ? 1 : (s.st ? 0 : 2);
        op.tmo  = s.tmo;
        op.r    = s.r;
        op.a    = s.a;
        op.d    = (op.kind == 0) ? rf_m[s.r] : ((op.kind == 1) ? mem_m[s.a] : '0);
        op.t    = cyc;
        sb_q.push_back(op);
        void'(stim_q.pop_front());
      end
    end else begin
      bus.dec_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (stim_q.size() > 0 || sb_q.size() > 0); i++) tick();
    chk(tag, stim_q.size() + sb_q.size(), 0);
  endtask

  task automatic snap();
    base_done = n_done;
    base_err  = n_errp;
    base_rfwe = n_rfwe;
    base_req  = req_total;
  endtask

  task automatic add(input bit ld, input bit st, input bit tmo, input int r, input int a);
    stim_t s;
    s.ld = ld; s.st = st; s.tmo = tmo; s.r = RA'(r); s.a = MA'(a);
    stim_q.push_back(s);
  endtask

  initial begin
    rst = 1'b1;
    bus.dec_valid = 1'b0; bus.dec_ld = 1'b0; bus.dec_st = 1'b0;
    bus.dec_reg_addr = '0; bus.dec_mem_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      rf_m[i]  = 32'h1000_0000 + i;
      mem_m[i] = 32'h2000_0000 + i;
    end

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.dec_ready, 1);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rfwe", bus.rf_we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;

    // store with ack after two wait cycles
    rf_m[3] = 32'hDEAD_BEEF;
    ack_delay = 2;
    snap();
    add(0, 1, 0, 3, 5);
    drain("drain_store", 30);
    chk("st_req_len", req_len_last, 3);
    chk("st_mem", mem_m[5], 32'hDEAD_BEEF);
    chk("st_done_cnt", n_done - base_done, 1);
    chk("st_rfwe_cnt", n_rfwe - base_rfwe, 0);
    chk("st_latency", done_lat_last, 4);
    tick();
    chk("st_ready_after", bus.dec_ready, 1);

    // load with ack in the first REQ cycle
    mem_m[9] = 32'h1234_5678;
    ack_delay = 0;
    snap();
    add(1, 0, 0, 7, 9);
    drain("drain_load", 30);
    chk("ld_rf", rf_m[7], 32'h1234_5678);
    chk("ld_rfwe_cnt", n_rfwe - base_rfwe, 1);
    chk("ld_done_cnt", n_done - base_done, 1);
    chk("ld_latency", done_lat_last, 3);
    tick();
    chk("ld_ready_after", bus.dec_ready, 1);

    // invalid op: err only
    snap();
    add(0, 0, 0, 2, 4);
    drain("drain_inv", 30);
    chk("inv_err_cnt", n_errp - base_err, 1);
    chk("inv_req_cnt", req_total - base_req, 0);
    chk("inv_done_cnt", n_done - base_done, 0);

    // both flags: load wins
    mem_m[2] = 32'hCAFE_F00D;
    snap();
    add(1, 1, 0, 1, 2);
    drain("drain_both", 30);
    chk("both_rf", rf_m[1], 32'hCAFE_F00D);
    chk("both_done_cnt", n_done - base_done, 1);

    // back-to-back with dec_valid held high
    snap();
    add(0, 1, 0, 3, 10);
    add(1, 0, 0, 4, 10);
    add(0, 1, 0, 4, 11);
    drain("drain_b2b", 60);
    chk("b2b_done_cnt", n_done - base_done, 3);
    chk("b2b_rf4", rf_m[4], 32'hDEAD_BEEF);
    chk("b2b_mem11", mem_m[11], 32'hDEAD_BEEF);
    chk("b2b_last_lat", done_lat_last, 2);

    // reset in the middle of REQ, then a late ack
    ack_delay = 1000;
    add(0, 1, 0, 3, 6);
    for (int i = 0; i < 10 && !bus.mem_req; i++) tick();
    chk("rst_mid_req_seen", bus.mem_req, 1);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("rstmid_req", bus.mem_req, 0);
    chk("rstmid_ready", bus.dec_ready, 1);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("rstmid_no_req", bus.mem_req, 0);
      chk("rstmid_no_rfwe", bus.rf_we, 0);
      chk("rstmid_no_done", bus.done, 0);
      chk("rstmid_no_err", bus.err, 0);
    end
    req_cyc = 0;

`ifdef MMU_TIMEOUT_EN
    // no ack: abort after four REQ cycles
    snap();
    add(0, 1, 1, 3, 12);
    drain("drain_tmo", 30);
    chk("tmo_req_len", req_len_last, 4);
    chk("tmo_err_cnt", n_errp - base_err, 1);
    chk("tmo_rfwe_cnt", n_rfwe - base_rfwe, 0);

    // ack on the fourth REQ cycle completes normally
    ack_delay = 3;
    mem_m[13] = 32'h0BAD_CAFE;
    snap();
    add(1, 0, 0, 8, 13);
    drain("drain_tmo_ack", 30);
    chk("tmoack_req_len", req_len_last, 4);
    chk("tmoack_rf", rf_m[8], 32'h0BAD_CAFE);
    chk("tmoack_done_cnt", n_done - base_done, 1);
    chk("tmoack_err_cnt", n_errp - base_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

endmodule
